// File: rtl/jls_ctrl_pkg.sv
// rtl/jls_ctrl_pkg.sv - shared state type, phase defaults and size limits for the JPEG-LS frame sequencer
package jls_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOF,
        ST_PIX,
        ST_GAP,
        ST_WAIT
    } jls_ctrl_state_t;

    localparam int          JLS_SOF_CYCLES = 368;
    localparam int          JLS_GAP_CYCLES = 16;
    localparam logic [13:0] JLS_W_M1_MIN   = 14'd4;
    localparam logic [13:0] JLS_H_M1_MAX   = 14'd16382;

    function automatic logic jls_size_ok(input logic [13:0] w_m1, input logic [13:0] h_m1);
        return (w_m1 >= JLS_W_M1_MIN) && (h_m1 <= JLS_H_M1_MAX);
    endfunction

endpackage

// File: rtl/jls_enc_ctrl.sv
// rtl/jls_enc_ctrl.sv - frame sequencer driving jls_encoder: SOF preamble, paced pixels, gap, completion tracking
module jls_enc_ctrl
    import jls_ctrl_pkg::*;
#(
    parameter int SOF_CYCLES = JLS_SOF_CYCLES,
    parameter int GAP_CYCLES = JLS_GAP_CYCLES,
    parameter int WCNT_W     = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [13:0]       i_cmd_w,
    input  logic [13:0]       i_cmd_h,
    input  logic              i_pix_valid,
    output logic              o_pix_ready,
    input  logic [7:0]        i_pix,
    output logic              o_enc_sof,
    output logic [13:0]       o_enc_w,
    output logic [13:0]       o_enc_h,
    output logic              o_enc_e,
    output logic [7:0]        o_enc_x,
    input  logic              i_enc_e,
    input  logic              i_enc_last,
    output logic              o_busy,
    output logic              o_done,
    output logic [WCNT_W-1:0] o_words,
    output logic              o_err
);

    // SOF loads SOF_CYCLES-1, GAP loads GAP_CYCLES (its first cycle carries the last pixel)
    localparam int PH_MAX = (SOF_CYCLES - 1 > GAP_CYCLES) ? (SOF_CYCLES - 1) : GAP_CYCLES;
    localparam int CNT_W  = (PH_MAX > 1) ? $clog2(PH_MAX + 1) : 1;

    jls_ctrl_state_t   r_state;
    logic [CNT_W-1:0]  r_phase_cnt;
    logic [13:0]       r_w;
    logic [13:0]       r_h;
    logic [13:0]       r_col;
    logic [13:0]       r_row;
    logic [WCNT_W-1:0] r_wcnt;
    logic              r_seen_last;

    logic              r_cmd_ready;
    logic              r_pix_ready;
    logic              r_enc_sof;
    logic [13:0]       r_enc_w;
    logic [13:0]       r_enc_h;
    logic              r_enc_e;
    logic [7:0]        r_enc_x;
    logic              r_busy;
    logic              r_done;
    logic [WCNT_W-1:0] r_words;
    logic              r_err;

    logic              w_pix_xfer;
    logic              w_enc_last;
    logic [WCNT_W-1:0] w_wcnt_inc;

    assign w_pix_xfer = i_pix_valid & r_pix_ready;
    assign w_enc_last = i_enc_e & i_enc_last;
    assign w_wcnt_inc = (&r_wcnt) ? r_wcnt : r_wcnt + WCNT_W'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_phase_cnt <= '0;
            r_w         <= '0;
            r_h         <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_wcnt      <= '0;
            r_seen_last <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_pix_ready <= 1'b0;
            r_enc_sof   <= 1'b0;
            r_enc_w     <= '0;
            r_enc_h     <= '0;
            r_enc_e     <= 1'b0;
            r_enc_x     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_words     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_enc_e <= 1'b0;
            r_enc_x <= '0;

            // Encoder output is only attributed to a frame while one is in flight
            if (r_state != ST_IDLE && i_enc_e) begin
                r_wcnt <= w_wcnt_inc;
                if (i_enc_last) begin
                    r_seen_last <= 1'b1;
                    r_done      <= 1'b1;
                    r_words     <= w_wcnt_inc;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (i_cmd_valid && r_cmd_ready) begin
                        if (jls_size_ok(i_cmd_w, i_cmd_h)) begin
                            r_w         <= i_cmd_w;
                            r_h         <= i_cmd_h;
                            r_col       <= '0;
                            r_row       <= '0;
                            r_wcnt      <= '0;
                            r_seen_last <= 1'b0;
                            r_phase_cnt <= CNT_W'(SOF_CYCLES - 1);
                            r_enc_sof   <= 1'b1;
                            r_enc_w     <= i_cmd_w;
                            r_enc_h     <= i_cmd_h;
                            r_cmd_ready <= 1'b0;
                            r_busy      <= 1'b1;
                            r_state     <= ST_SOF;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_SOF: begin
                    if (r_phase_cnt == '0) begin
                        r_enc_sof   <= 1'b0;
                        r_enc_w     <= '0;
                        r_enc_h     <= '0;
                        r_pix_ready <= 1'b1;
                        r_state     <= ST_PIX;
                    end else begin
                        r_phase_cnt <= r_phase_cnt - CNT_W'(1);
                    end
                end
                ST_PIX: begin
                    if (w_pix_xfer) begin
                        r_enc_e <= 1'b1;
                        r_enc_x <= i_pix;
                        if (r_col == r_w) begin
                            r_col <= '0;
                            if (r_row == r_h) begin
                                r_pix_ready <= 1'b0;
                                r_phase_cnt <= CNT_W'(GAP_CYCLES);
                                r_state     <= ST_GAP;
                            end else begin
                                r_row <= r_row + 14'd1;
                            end
                        end else begin
                            r_col <= r_col + 14'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_phase_cnt == '0) begin
                        // A last beat landing on the final gap cycle still counts as seen
                        if (r_seen_last || w_enc_last) begin
                            r_cmd_ready <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end else begin
                        r_phase_cnt <= r_phase_cnt - CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (w_enc_last) begin
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_cmd_ready = r_cmd_ready;
    assign o_pix_ready = r_pix_ready;
    assign o_enc_sof   = r_enc_sof;
    assign o_enc_w     = r_enc_w;
    assign o_enc_h     = r_enc_h;
    assign o_enc_e     = r_enc_e;
    assign o_enc_x     = r_enc_x;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_words     = r_words;
    assign o_err       = r_err;

endmodule

// File: tb/tb_jls_enc_ctrl.sv
// tb/tb_jls_enc_ctrl.sv - scoreboard bench for jls_enc_ctrl frame sequencing and completion reporting
module tb_jls_enc_ctrl;

    localparam int SOF = 368;
    localparam int GAP = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        i_cmd_valid = 1'b0;
    logic        o_cmd_ready;
    logic [13:0] i_cmd_w = '0;
    logic [13:0] i_cmd_h = '0;
    logic        i_pix_valid = 1'b0;
    logic        o_pix_ready;
    logic [7:0]  i_pix = '0;
    logic        o_enc_sof;
    logic [13:0] o_enc_w;
    logic [13:0] o_enc_h;
    logic        o_enc_e;
    logic [7:0]  o_enc_x;
    logic        i_enc_e = 1'b0;
    logic        i_enc_last = 1'b0;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_words;
    logic        o_err;

    always #5 clk = ~clk;

    jls_enc_ctrl #(
        .SOF_CYCLES (SOF),
        .GAP_CYCLES (GAP),
        .WCNT_W     (32)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd_w     (i_cmd_w),
        .i_cmd_h     (i_cmd_h),
        .i_pix_valid (i_pix_valid),
        .o_pix_ready (o_pix_ready),
        .i_pix       (i_pix),
        .o_enc_sof   (o_enc_sof),
        .o_enc_w     (o_enc_w),
        .o_enc_h     (o_enc_h),
        .o_enc_e     (o_enc_e),
        .o_enc_x     (o_enc_x),
        .i_enc_e     (i_enc_e),
        .i_enc_last  (i_enc_last),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_words     (o_words),
        .o_err       (o_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  q_x[$];
    logic [31:0] q_words[$];
    logic [27:0] q_wh[$];
    int          q_err[$];

    int   ncyc = 0;
    int   hs_n = -1;
    int   sof_run = 0;
    int   e_cnt = 0;
    int   first_e_n = 0;
    int   last_e_n = 0;
    int   rdy_rise_n = 0;
    logic prev_acc = 1'b0;
    logic prev_sof = 1'b0;
    logic prev_pr = 1'b0;
    logic prev_rdy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        $display("FAIL %s: got an unexpected event, expected none", name);
    endtask

    task automatic timed_out(input string name);
        n_checks++;
        $display("FAIL %s: got timeout, expected the event within its bound", name);
    endtask

    // Monitor: pops the scoreboard queues whenever the DUT presents an output
    always @(negedge clk) begin
        ncyc++;
        if (!rstn) begin
            prev_acc = 1'b0;
            prev_sof = 1'b0;
            prev_pr  = 1'b0;
            prev_rdy = 1'b0;
            sof_run  = 0;
            hs_n     = -1;
        end else begin
            if (o_enc_e || prev_acc) check("enc_e_pace", o_enc_e, prev_acc);
            if (o_enc_e) begin
                if (e_cnt == 0) first_e_n = ncyc;
                e_cnt++;
                last_e_n = ncyc;
                if (q_x.size() == 0) unexpected("enc_x");
                else check("enc_x", o_enc_x, q_x.pop_front());
            end
            if (o_enc_sof) begin
                if (!prev_sof) begin
                    if (q_wh.size() == 0) unexpected("sof_start");
                    else check("sof_wh", {o_enc_w, o_enc_h}, q_wh.pop_front());
                end
                sof_run++;
            end else if (prev_sof) begin
                check("sof_len", sof_run, SOF);
                check("wh_clear", {o_enc_w, o_enc_h}, 0);
                sof_run = 0;
            end
            if (o_pix_ready && !prev_pr) check("pix_ready_lat", ncyc - hs_n, SOF + 1);
            if (o_cmd_ready && !prev_rdy) rdy_rise_n = ncyc;
            if (o_done) begin
                if (q_words.size() == 0) unexpected("done");
                else check("done_words", o_words, q_words.pop_front());
            end
            if (o_err) begin
                if (q_err.size() == 0) unexpected("err");
                else begin
                    void'(q_err.pop_front());
                    check("err_lat", ncyc - hs_n, 1);
                end
            end
            if (o_cmd_ready && i_cmd_valid) hs_n = ncyc;
            prev_acc = o_pix_ready && i_pix_valid;
            prev_sof = o_enc_sof;
            prev_pr  = o_pix_ready;
            prev_rdy = o_cmd_ready;
        end
    end

    // All stimulus tasks start and end one time unit after a rising edge
    task automatic send_cmd(input int w, input int h, input bit ok);
        int t = 0;
        i_cmd_valid = 1'b1;
        i_cmd_w     = 14'(w);
        i_cmd_h     = 14'(h);
        if (ok) q_wh.push_back({14'(w), 14'(h)});
        else q_err.push_back(1);
        do begin
            @(negedge clk);
            t++;
        end while (!o_cmd_ready && t < 2000);
        if (!o_cmd_ready) timed_out("cmd_accept");
        @(posedge clk);
        #1;
        i_cmd_valid = 1'b0;
    endtask

    task automatic send_pix(input int n, input bit bubbles);
        for (int i = 0; i < n; i++) begin
            int bub;
            int t;
            bub = bubbles ? ((i * 5 + 1) % 3) : 0;
            if (bub > 0) begin
                i_pix_valid = 1'b0;
                repeat (bub) @(posedge clk);
                #1;
            end
            i_pix_valid = 1'b1;
            i_pix       = 8'(i);
            t = 0;
            @(negedge clk);
            while (!o_pix_ready && t < 2000) begin
                @(negedge clk);
                t++;
            end
            if (!o_pix_ready) begin
                timed_out("pix_accept");
                i_pix_valid = 1'b0;
                return;
            end
            q_x.push_back(8'(i));
            @(posedge clk);
            #1;
        end
        i_pix_valid = 1'b0;
    endtask

    task automatic enc_beats(input int delay, input int n, input bit with_last, input int exp_words);
        if (delay > 0) begin
            repeat (delay) @(posedge clk);
            #1;
        end
        for (int k = 0; k < n; k++) begin
            i_enc_e    = 1'b1;
            i_enc_last = with_last && (k == n - 1);
            if (i_enc_last && exp_words >= 0) q_words.push_back(32'(exp_words));
            @(posedge clk);
            #1;
        end
        i_enc_e    = 1'b0;
        i_enc_last = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!o_cmd_ready && t < 3000);
        if (!o_cmd_ready) timed_out(name);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation time limit, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   t;

        repeat (3) @(negedge clk);
        check("rst_ctrl", {o_cmd_ready, o_pix_ready, o_enc_sof, o_enc_e, o_busy, o_done, o_err}, 0);
        check("rst_data", {o_enc_w, o_enc_h, o_enc_x}, 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        check("ready_before_clk", o_cmd_ready, 0);
        @(negedge clk);
        check("ready_after_clk", o_cmd_ready, 1);
        @(posedge clk);
        #1;

        // Frame A: 8x4, continuous pixels, 5 encoder words ending during PIX
        send_cmd(7, 3, 1);
        e_cnt = 0;
        fork
            send_pix(32, 0);
            enc_beats(380, 5, 1, 5);
        join
        wait_idle("idle_a");
        check("count_a", e_cnt, 32);
        check("span_a", last_e_n - first_e_n, 31);
        check("gap_a", rdy_rise_n - last_e_n, GAP + 1);
        check("busy_a", o_busy, 0);

        // Frame B: same size with bubbles in the pixel stream
        send_cmd(7, 3, 1);
        e_cnt = 0;
        fork
            send_pix(32, 1);
            enc_beats(400, 3, 1, 3);
        join
        wait_idle("idle_b");
        check("count_b", e_cnt, 32);

        // Rejected commands: width too small, height too large
        send_cmd(3, 3, 0);
        acc = 1'b0;
        repeat (20) begin
            @(negedge clk);
            acc |= o_busy | o_enc_sof;
        end
        check("inv_w_idle", acc, 0);
        check("inv_w_ready", o_cmd_ready, 1);
        @(posedge clk);
        #1;
        send_cmd(4, 16383, 0);
        acc = 1'b0;
        repeat (20) begin
            @(negedge clk);
            acc |= o_busy | o_enc_sof;
        end
        check("inv_h_idle", acc, 0);
        @(posedge clk);
        #1;

        // Minimum width frame whose last word arrives well after GAP
        send_cmd(4, 0, 1);
        e_cnt = 0;
        fork
            send_pix(5, 0);
            enc_beats(369, 2, 0, -1);
        join
        repeat (GAP + 40) @(posedge clk);
        @(negedge clk);
        check("wait_ready", o_cmd_ready, 0);
        check("wait_busy", o_busy, 1);
        @(posedge clk);
        #1;
        enc_beats(0, 1, 1, 3);
        t = 0;
        while (!o_done && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (o_done) check("done_ready_same", o_cmd_ready, 1);
        else timed_out("wait_done");
        check("count_c", e_cnt, 5);
        @(posedge clk);
        #1;

        // Reset in the middle of PIX
        send_cmd(7, 3, 1);
        send_pix(10, 0);
        #2;
        rstn = 1'b0;
        #1;
        check("rst_mid_ctrl", {o_cmd_ready, o_pix_ready, o_enc_sof, o_enc_e, o_busy, o_done, o_err}, 0);
        check("rst_mid_data", {o_enc_w, o_enc_h, o_enc_x}, 0);
        check("rst_mid_words", o_words, 0);
        q_x.delete();
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        wait_idle("idle_rst");

        // Stray encoder beats while idle must not count toward the next frame
        enc_beats(0, 3, 1, -1);
        repeat (4) @(posedge clk);
        #1;
        send_cmd(7, 3, 1);
        e_cnt = 0;
        fork
            send_pix(32, 0);
            enc_beats(380, 4, 1, 4);
        join
        wait_idle("idle_d");
        check("count_d", e_cnt, 32);

        repeat (5) @(negedge clk);
        check("q_x_drained", q_x.size(), 0);
        check("q_words_drained", q_words.size(), 0);
        check("q_wh_drained", q_wh.size(), 0);
        check("q_err_drained", q_err.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/jls_enc_ctrl.md
# jls_enc_ctrl

Frame sequencer in front of `jls_encoder`. Accepts one frame command (size) and a valid/ready 8-bit pixel stream, and generates the encoder's frame protocol: `i_sof` preamble, paced `i_e`/`i_x` pixels, inter-frame idle gap. It observes the encoder's output stream to report per-frame completion and compressed size. It replaces hand-written stimulus sequencing wherever the encoder is driven from a DMA or sensor source.

## Interface
Parameters:
- SOF_CYCLES, 368, cycles `o_enc_sof` is held high before the first pixel
- GAP_CYCLES, 16, idle cycles after the last pixel of a frame
- WCNT_W, 32, width of the compressed-word counter

Ports:
- clk  in  1  clock; single clock domain
- rstn  in  1  reset, asynchronous, active-low
- i_cmd_valid  in  1  frame command valid
- o_cmd_ready  out  1  command accepted when both are high
- i_cmd_w  in  14  image width minus 1
- i_cmd_h  in  14  image height minus 1
- i_pix_valid  in  1  pixel valid
- o_pix_ready  out  1  pixel accepted when both are high
- i_pix  in  8  pixel value, raster order
- o_enc_sof, o_enc_w[13:0], o_enc_h[13:0], o_enc_e, o_enc_x[7:0]  out  drive encoder `i_sof`/`i_w`/`i_h`/`i_e`/`i_x`
- i_enc_e, i_enc_last  in  1 each  encoder `o_e`, `o_last`; data is not needed
- o_busy  out  1  frame in progress, i.e. state ≠ IDLE
- o_done  out  1  one-cycle frame-complete pulse
- o_words  out  WCNT_W  16-bit words of the completed frame, valid with `o_done`
- o_err  out  1  one-cycle pulse: rejected command

## Operation
- The FSM has five states: IDLE, SOF, PIX, GAP, WAIT.
- IDLE: `o_cmd_ready`=1.
  - On handshake with valid size, latch w/h, clear the row/column counters and the word counter, clear `seen_last`, then go to SOF.
  - Valid size is `i_cmd_w` ≥ 4 and `i_cmd_h` ≤ 16382.
  - On an invalid size, accept the command, pulse `o_err` the next cycle, and stay in IDLE.
- SOF: `o_enc_sof`=1 with `o_enc_w`/`o_enc_h` = latched values, for exactly SOF_CYCLES cycles, then go to PIX.
- PIX: `o_pix_ready`=1.
  - Each transfer registers `o_enc_e`=1 and `o_enc_x`=`i_pix` for one cycle. With no transfer, `o_enc_e`=0 and `o_enc_x`=0, so bubbles are legal.
  - A column counter runs 0..w-1 and a row counter 0..h-1; no multiplier is used.
  - The transfer at (h-1, w-1) moves the FSM to GAP; `o_pix_ready` drops in the same cycle as that transfer's acceptance edge.
- GAP: all encoder inputs are 0 for GAP_CYCLES cycles. Then go to WAIT if `seen_last`=0, otherwise IDLE.
- WAIT: hold encoder inputs at 0 until `i_enc_e & i_enc_last`, then go to IDLE.
- Output monitoring, in SOF/PIX/GAP/WAIT:
  - Each `i_enc_e` increments the word counter, saturating at all-ones.
  - `i_enc_e & i_enc_last` sets `seen_last`, registers `o_done`=1 and `o_words` = count including that word.
- `i_enc_e` in IDLE is ignored: no count, no `o_done`.
- `o_enc_w`/`o_enc_h` are 0 outside SOF.

## Timing
- Reset values: all outputs 0 (including `o_cmd_ready`); state IDLE. After reset release `o_cmd_ready`=1 on the first clock.
- Reset mid-frame returns to IDLE asynchronously with all outputs 0. No `o_done` or `o_err` is generated.
- Command handshake at edge T: `o_enc_sof` is high for cycles T+1 … T+SOF_CYCLES. `o_pix_ready` first goes high in cycle T+SOF_CYCLES+1.
- Pixel accepted at edge P: `o_enc_e` is high in cycle P+1. Throughput is one pixel per clock.
- After the last pixel's `o_enc_e` cycle, there are exactly GAP_CYCLES zero cycles before IDLE or WAIT.
- `o_done` is high in the cycle after the `i_enc_last` beat. If `i_enc_last` arrives during GAP, the FSM returns to IDLE directly after GAP.
- `o_cmd_ready` rises in the cycle the FSM enters IDLE. Back-to-back frames are therefore separated by ≥ GAP_CYCLES idle cycles.

## Structure
- Package `jls_ctrl_pkg` holds:
  - state enum `jls_ctrl_state_t`
  - default SOF_CYCLES and GAP_CYCLES
  - size limits `JLS_W_M1_MIN`=4 and `JLS_H_M1_MAX`=16382
- Single flat module. Counters and FSM are inline; no sub-module.
- The SOF and GAP phases share one down-counter sized for the larger parameter.

## Test plan
- Command w-1=7, h-1=3, pixels 0..31 continuous, encoder model returns 5 words with last on the 5th → `o_enc_sof` high exactly 368 cycles, 32 consecutive `o_enc_e`, 16 idle cycles, `o_done`=1 with `o_words`=5.
- Same frame with random `i_pix_valid` gaps → identical `o_enc_x` sequence, with `o_enc_e` low exactly where transfers are absent.
- Command w-1=3 (width 4) → `o_err` pulse, no `o_enc_sof`, `o_busy` stays 0. Command h-1=16383 → same result.
- `i_enc_last` delayed 40 cycles past GAP → FSM stays in WAIT with `o_cmd_ready`=0, then `o_done` follows the last beat and `o_cmd_ready` rises.
- Assert `rstn`=0 in the middle of PIX → all outputs 0 immediately. A new command after release restarts with a full 368-cycle SOF.
- Stray `i_enc_e`/`i_enc_last` while IDLE → no `o_done`, and the next frame's `o_words` excludes the stray beats.
